// File: rtl/music_sequencer.sv
// Melody sequencer feeding the tone generator: walks a packed (scale, time) table, one note per
// enable/finish handshake with an enable-low gap between notes. Define MUSIC_SEQ_LOOP_EN to loop forever.
module music_sequencer #(
  parameter int                LEN        = 8,
  parameter logic [0:14*LEN-1] MELODY     = '0,
  parameter int                GAP_CYCLES = 50_000,
  parameter int                IDX_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             music_finish,
  output logic             music_en,
  output logic [2:0]       music_scale,
  output logic [10:0]      music_time,
  output logic             mute,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] note_idx
);

  localparam int CW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t           state, state_nx;
  logic [1:0]       fin_pipe;
  logic             fin_s;
  logic [CW-1:0]    gap_cnt;
  logic [2:0]       scale_r;
  logic [10:0]      time_r;
  logic             mute_r, done_r;
  logic             load, done_nx, last;
  logic [IDX_W-1:0] idx_nx;
  logic [13:0]      ent;

  function automatic logic [13:0] entry(input logic [IDX_W-1:0] i);
    return MELODY[int'(i)*14 +: 14];
  endfunction

  assign fin_s = fin_pipe[1];
  assign last  = (note_idx == IDX_W'(LEN-1));
  assign ent   = entry(idx_nx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fin_pipe <= '0;
      note_idx <= '0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_nx;
      fin_pipe <= {fin_pipe[0], music_finish};
      note_idx <= idx_nx;
      done_r   <= done_nx;
    end
  end

  // Entry registers only reload when a new note index is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scale_r <= '0;
      time_r  <= '0;
      mute_r  <= 1'b0;
    end else if (load) begin
      mute_r  <= (ent[13:11] == 3'd7);
      scale_r <= (ent[13:11] == 3'd7) ? 3'd0 : ent[13:11];
      time_r  <= ent[10:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      gap_cnt <= '0;
    else if (state == PLAY && state_nx == GAP)
      gap_cnt <= CW'(GAP_CYCLES-1);
    else if (state == GAP && gap_cnt != '0)
      gap_cnt <= gap_cnt - 1'b1;
  end

  always_comb begin
    state_nx = state;
    idx_nx   = note_idx;
    load     = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: if (start && !stop) begin
        state_nx = PLAY;
        idx_nx   = '0;
        load     = 1'b1;
      end
      PLAY: begin
        if (stop)       state_nx = IDLE;
        else if (fin_s) state_nx = GAP;
      end
      GAP: begin
        // Wait for the generator's finish to clear as well as the gap timer.
        if (stop) state_nx = IDLE;
        else if (gap_cnt == '0 && !fin_s) begin
          if (last) begin
            done_nx = 1'b1;
`ifdef MUSIC_SEQ_LOOP_EN
            state_nx = PLAY;
            idx_nx   = '0;
            load     = 1'b1;
`else
            state_nx = IDLE;
`endif
          end else begin
            state_nx = PLAY;
            idx_nx   = note_idx + 1'b1;
            load     = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    music_en    = (state == PLAY);
    music_scale = busy ? scale_r : 3'd0;
    music_time  = busy ? time_r : 11'd0;
    mute        = busy & mute_r;
    done        = done_r;
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer: vector table, random finish timing against
// timing formulas, reset/abort sequences and a LEN=2 completion/loop check.
module tb_music_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 0, stop = 0, fin = 0;
  logic        en, sc_dummy, mu, bz, dn;
  logic [2:0]  sc;
  logic [10:0] tm;
  logic [7:0]  idx;
  logic        start2 = 0, stop2 = 0, fin2 = 0;
  logic        en2, mu2, bz2, dn2;
  logic [2:0]  sc2;
  logic [10:0] tm2;
  logic [7:0]  idx2;

  localparam int G = 4;
  int sc_tab [3] = '{0, 7, 6};
  int tm_tab [3] = '{5, 3, 1};
  int sc2_tab[2] = '{2, 5};
  int tm2_tab[2] = '{9, 0};

  int checks = 0, failures = 0;
  int dcount = 0, bz_fell = 0;

  always #5 clk = ~clk;

  music_sequencer #(.LEN(3), .GAP_CYCLES(G), .IDX_W(8),
    .MELODY({3'd0, 11'd5, 3'd7, 11'd3, 3'd6, 11'd1})) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .music_finish(fin),
    .music_en(en), .music_scale(sc), .music_time(tm), .mute(mu), .busy(bz),
    .done(dn), .note_idx(idx));

  music_sequencer #(.LEN(2), .GAP_CYCLES(3), .IDX_W(8),
    .MELODY({3'd2, 11'd9, 3'd5, 11'd0})) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop2), .music_finish(fin2),
    .music_en(en2), .music_scale(sc2), .music_time(tm2), .mute(mu2), .busy(bz2),
    .done(dn2), .note_idx(idx2));

  wire [25:0] obs  = {en, sc, tm, mu, bz, dn, idx};
  wire [25:0] obs2 = {en2, sc2, tm2, mu2, bz2, dn2, idx2};

  typedef struct { bit st, sp, fn; int kind; int i; } vec_t;  // kind: 0 idle,1 play,2 gap,3 done
  vec_t tv[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected outputs from the melody rules: rest (7) shows scale 0 with mute, idle shows zeros.
  function automatic logic [25:0] expv(input int kind, input int i);
    logic b, m;
    logic [2:0] s;
    logic [10:0] t;
    b = (kind == 1 || kind == 2);
    m = 1'b0; s = 3'd0; t = 11'd0;
    if (b) begin
      m = (sc_tab[i] == 7);
      s = m ? 3'd0 : 3'(sc_tab[i]);
      t = 11'(tm_tab[i]);
    end
    return {(kind == 1), s, t, m, b, (kind == 3), 8'(i)};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_en(input bit v, input string nm);
    int n = 0;
    while (en !== v && n < 50) begin step(); n++; end
    chk(nm, en, v);
  endtask

  function automatic vec_t v(input bit st, input bit sp, input bit fn, input int kind, input int i);
    vec_t r;
    r.st = st; r.sp = sp; r.fn = fn; r.kind = kind; r.i = i;
    return r;
  endfunction

  task automatic rand_run(input int r);
    int d, h, n, low;
    start = 1; step(); start = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("run%0d note%0d fields", r, i), obs, expv(1, i));
      d = $urandom_range(4);
      repeat (d) step();
      fin = 1; n = 0;
      do begin step(); n++; end while (en && n < 20);
      chk($sformatf("run%0d note%0d fin->en fall", r, i), n, 3);
      h = $urandom_range(7);
      repeat (h) step();
      fin = 0; low = h + 1;
      forever begin
        step();
        if (en || dn || low > 60) break;
        low++;
      end
      chk($sformatf("run%0d note%0d gap len", r, i), low, (h + 3 > G) ? h + 3 : G);
    end
    chk($sformatf("run%0d done+idle", r), {dn, bz}, 2'b10);
    step();
    chk($sformatf("run%0d done single", r), dn, 0);
  endtask

  task automatic note2();
    int n = 0;
    fin2 = 1;
    while (en2 && n < 20) begin step(); if (!bz2) bz_fell = 1; n++; end
    fin2 = 0; n = 0;
    forever begin
      step();
      if (dn2) dcount++;
      if (!bz2) bz_fell = 1;
      if (en2 || !bz2 || n > 40) break;
      n++;
    end
  endtask

  initial begin
    int passes, dseen;
    #3;
    chk("reset outputs", obs, 26'd0);
    chk("reset outputs dut2", obs2, 26'd0);
    step(); rst_n = 1; step();

`ifndef MUSIC_SEQ_LOOP_EN
    tv.push_back(v(1,0,0,1,0)); tv.push_back(v(0,0,1,1,0)); tv.push_back(v(0,0,1,1,0));
    tv.push_back(v(0,0,1,2,0)); tv.push_back(v(0,0,0,2,0)); tv.push_back(v(1,0,0,2,0));
    tv.push_back(v(0,0,0,2,0)); tv.push_back(v(0,0,0,1,1)); tv.push_back(v(0,0,1,1,1));
    tv.push_back(v(0,0,1,1,1)); tv.push_back(v(0,0,1,2,1));
    for (int k = 0; k < 6; k++) tv.push_back(v(0,0,1,2,1));
    tv.push_back(v(0,0,0,2,1)); tv.push_back(v(0,0,0,2,1)); tv.push_back(v(0,0,0,1,2));
    tv.push_back(v(0,0,1,1,2)); tv.push_back(v(0,0,1,1,2)); tv.push_back(v(0,0,1,2,2));
    tv.push_back(v(0,0,0,2,2)); tv.push_back(v(0,0,0,2,2)); tv.push_back(v(0,0,0,2,2));
    tv.push_back(v(0,0,0,3,2)); tv.push_back(v(0,0,0,0,2)); tv.push_back(v(1,1,0,0,2));
    foreach (tv[k]) begin
      start = tv[k].st; stop = tv[k].sp; fin = tv[k].fn;
      step();
      chk($sformatf("vec%0d", k), obs, expv(tv[k].kind, tv[k].i));
    end
    start = 0; stop = 0; fin = 0;
    step(); step();

    for (int r = 0; r < 6; r++) rand_run(r);

    // Abort in the rest note's gap with start asserted alongside stop.
    start = 1; step(); start = 0;
    fin = 1; wait_en(0, "abort note0 fall");
    fin = 0; wait_en(1, "abort note1 rise");
    chk("abort note1 rest", obs, expv(1, 1));
    fin = 1; wait_en(0, "abort note1 fall");
    step(); step();
    stop = 1; start = 1; fin = 0;
    step();
    chk("abort idle", obs, expv(0, 1));
    stop = 0; start = 0; dseen = 0;
    repeat (10) begin step(); dseen |= dn; end
    chk("abort no done", dseen, 0);
    start = 1; step(); start = 0;
    chk("restart at 0", obs, expv(1, 0));
`endif

    // Asynchronous reset while a note plays.
    start = 1; step(); start = 0;
    chk("pre-reset en", en, 1);
    #1 rst_n = 0;
    #1;
    chk("async reset", obs, 26'd0);
    step(); rst_n = 1; step();

`ifdef MUSIC_SEQ_LOOP_EN
    passes = 2;
`else
    passes = 1;
`endif
    start2 = 1; step(); start2 = 0;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("len2 pass%0d note%0d", p, i), obs2,
            {1'b1, 3'(sc2_tab[i]), 11'(tm2_tab[i]), 1'b0, 1'b1, (p > 0 && i == 0), 8'(i)});
        note2();
      end
    chk("len2 done count", dcount, passes);
`ifdef MUSIC_SEQ_LOOP_EN
    chk("loop busy held", bz_fell, 0);
    stop2 = 1; step(); stop2 = 0;
`endif
    chk("len2 idle at end", {bz2, en2}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
